// File: rtl/uart_axil_bridge.sv
// uart_axil_bridge: byte-stream to AXI-Lite master bridge for a UART slave.
// After reset the baud divisor (DVSR_INIT) is written to 0x01, then the bridge
// idles. A status read of 0x03 precedes every TX write. Bit 9 of that word is
// tx_full and bit 8 is rx_empty. A byte is written to 0x02 only when the slave
// reports room for it.
// Optional macro UART_BRIDGE_RX_EN enables the RX path: idle polling every
// POLL_INTERVAL clocks, with received bytes presented on m_rx_*. Without it,
// reads happen only for TX and m_rx_* are tied to 0.
// Ports:
//   clk, resetn       clock, asynchronous active-high reset
//   s_tx_*            TX byte stream in (valid/ready, one-cycle ready pulse)
//   m_rx_*            RX byte stream out (valid/ready)
//   o_cfg_done        divisor has been written since reset
//   m_axi_*           AXI-Lite master, one transaction outstanding
module uart_axil_bridge #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DVSR_INIT     = 650,
  parameter int unsigned POLL_INTERVAL = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            s_tx_data,
  input  logic                  s_tx_valid,
  output logic                  s_tx_ready,
  output logic [7:0]            m_rx_data,
  output logic                  m_rx_valid,
  input  logic                  m_rx_ready,
  output logic                  o_cfg_done,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [ADDR_WIDTH-1:0] AddrDvsr = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrTx   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] AddrStat = ADDR_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] DvsrWord = DATA_WIDTH'(DVSR_INIT);

  typedef enum logic [3:0] {
    StCfgAw, StCfgW, StCfgB, StIdle, StRdAr, StRdR, StWrAw, StWrW, StWrB
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        cfg_done_q, cfg_done_d;
  logic        start_rd;

  assign o_cfg_done  = cfg_done_q;
  assign m_axi_wstrb = 4'b1111;

`ifdef UART_BRIDGE_RX_EN
  localparam int unsigned PollW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PollW-1:0] PollMax = PollW'(POLL_INTERVAL - 1);

  logic [PollW-1:0] poll_q, poll_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             unused_rdata;

  // A held RX byte blocks all reads so the slave never pops a byte we cannot store.
  assign start_rd = (state_q == StIdle) && !rx_valid_q && (s_tx_valid || (poll_q == PollMax));

  always_comb begin
    poll_d     = poll_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (start_rd) begin
      poll_d = '0;
    end else if ((state_q == StIdle) && (poll_q != PollMax)) begin
      poll_d = poll_q + PollW'(1);
    end
    if (rx_valid_q && m_rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if ((state_q == StRdR) && m_axi_rvalid && !m_axi_rdata[8]) begin
      rx_valid_d = 1'b1;
      rx_data_d  = m_axi_rdata[7:0];
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      poll_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      poll_q     <= poll_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign m_rx_valid   = rx_valid_q;
  assign m_rx_data    = rx_data_q;
  assign unused_rdata = ^m_axi_rdata[DATA_WIDTH-1:10];
`else
  logic unused_rdata;

  assign start_rd     = (state_q == StIdle) && s_tx_valid;
  assign m_rx_valid   = 1'b0;
  assign m_rx_data    = 8'h00;
  assign unused_rdata = ^{m_rx_ready, m_axi_rdata[DATA_WIDTH-1:10], m_axi_rdata[8:0],
                          32'(POLL_INTERVAL)};
`endif

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= StCfgAw;
      tx_byte_q  <= 8'h00;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    cfg_done_d = cfg_done_q;
    unique case (state_q)
      StCfgAw: if (m_axi_awready) state_d = StCfgW;
      StCfgW:  if (m_axi_wready)  state_d = StCfgB;
      StCfgB: begin
        if (m_axi_bvalid) begin
          state_d    = StIdle;
          cfg_done_d = 1'b1;
        end
      end
      StIdle:  if (start_rd)      state_d = StRdAr;
      StRdAr:  if (m_axi_arready) state_d = StRdR;
      StRdR: begin
        if (m_axi_rvalid) begin
          // Latch the byte here so the write is immune to later s_tx_data changes.
          if (s_tx_valid && !m_axi_rdata[9]) begin
            state_d   = StWrAw;
            tx_byte_d = s_tx_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWrAw:  if (m_axi_awready) state_d = StWrW;
      StWrW:   if (m_axi_wready)  state_d = StWrB;
      StWrB:   if (m_axi_bvalid)  state_d = StIdle;
      default: state_d = StCfgAw;
    endcase
  end

  // Outputs are gated by reset so every valid drops the instant reset asserts.
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = '0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = '0;
    m_axi_rready  = 1'b0;
    s_tx_ready    = 1'b0;
    if (!resetn) begin
      unique case (state_q)
        StCfgAw: begin
          m_axi_awvalid = 1'b1;
          m_axi_awaddr  = AddrDvsr;
        end
        StCfgW: begin
          m_axi_wvalid = 1'b1;
          m_axi_wdata  = DvsrWord;
        end
        StCfgB:  m_axi_bready = 1'b1;
        StIdle:  ;
        StRdAr: begin
          m_axi_arvalid = 1'b1;
          m_axi_araddr  = AddrStat;
        end
        StRdR:   m_axi_rready = 1'b1;
        StWrAw: begin
          m_axi_awvalid = 1'b1;
          m_axi_awaddr  = AddrTx;
        end
        StWrW: begin
          m_axi_wvalid = 1'b1;
          m_axi_wdata  = {{(DATA_WIDTH-8){1'b0}}, tx_byte_q};
        end
        StWrB: begin
          m_axi_bready = 1'b1;
          s_tx_ready   = m_axi_bvalid;
        end
        default: ;
      endcase
    end
  end

endmodule
